mem_wb_stage: RTL

Pipeline register and write-back selection stage between the MEM stage and the register file. It captures the MEM stage's ALU result, memory read data, PC+4, destination register and control word on each clock edge. It then forms the final register write-back value, including byte/halfword load extraction, and drives the register-file write port and the WB forwarding source. It supports stall (hold) and flush (bubble), and keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back value selection, sub-word load extraction
// and a retired-instruction counter.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStall,
    input  logic        iFlush,
    input  logic        iValid,
    input  logic [31:0] iResult,
    input  logic [31:0] iReadData,
    input  logic [31:0] iControlSignal,
    input  logic [4:0]  iRegAddress,
    input  logic [31:0] iPC_plus_4,
    output logic [31:0] oControlSignal,
    output logic        oValid,
    output logic        oRegWrite,
    output logic [4:0]  oWriteAddr,
    output logic [31:0] oWriteData,
    output logic [31:0] oRetireCount
);

    localparam logic [1:0] MemtoRegAlu  = 2'b00;
    localparam logic [1:0] MemtoRegLoad = 2'b01;
    localparam logic [1:0] MemtoRegLink = 2'b10;

    localparam logic [1:0] LoadSizeHalf = 2'b01;
    localparam logic [1:0] LoadSizeByte = 2'b10;

    logic        validReg;
    logic [31:0] controlReg;
    logic [31:0] resultReg;
    logic [31:0] rdataReg;
    logic [31:0] pc4Reg;
    logic [4:0]  regAddrReg;
    logic [31:0] retireCountReg;

    logic        retireEnable;
    logic        regWriteBit;
    logic [1:0]  memtoReg;
    logic [1:0]  loadSize;
    logic        loadUnsigned;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;

    // The WB instruction departs on a normal advance or when a flush replaces it.
    assign retireEnable = validReg & (iFlush | ~iStall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validReg       <= 1'b0;
            controlReg     <= 32'd0;
            resultReg      <= 32'd0;
            rdataReg       <= 32'd0;
            pc4Reg         <= 32'd0;
            regAddrReg     <= 5'd0;
            retireCountReg <= 32'd0;
        end else begin
            if (retireEnable) begin
                retireCountReg <= retireCountReg + 32'd1;
            end
            if (iFlush) begin
                validReg   <= 1'b0;
                controlReg <= 32'd0;
                resultReg  <= 32'd0;
                rdataReg   <= 32'd0;
                pc4Reg     <= 32'd0;
                regAddrReg <= 5'd0;
            end else if (!iStall) begin
                validReg   <= iValid;
                controlReg <= iControlSignal;
                resultReg  <= iResult;
                rdataReg   <= iReadData;
                pc4Reg     <= iPC_plus_4;
                regAddrReg <= iRegAddress;
            end
        end
    end

    assign regWriteBit  = controlReg[13];
    assign memtoReg     = controlReg[15:14];
    assign loadSize     = controlReg[17:16];
    assign loadUnsigned = controlReg[18];

    always_comb begin
        loadByte = 8'd0;
        unique case (resultReg[1:0])
            2'b00: loadByte = rdataReg[7:0];
            2'b01: loadByte = rdataReg[15:8];
            2'b10: loadByte = rdataReg[23:16];
            2'b11: loadByte = rdataReg[31:24];
            default: loadByte = 8'd0;
        endcase
    end

    // Halfword alignment trusts result[1] only; odd addresses are not trapped here.
    assign loadHalf = resultReg[1] ? rdataReg[31:16] : rdataReg[15:0];

    always_comb begin
        loadData = rdataReg;
        if (loadSize == LoadSizeByte) begin
            loadData = {{24{~loadUnsigned & loadByte[7]}}, loadByte};
        end else if (loadSize == LoadSizeHalf) begin
            loadData = {{16{~loadUnsigned & loadHalf[15]}}, loadHalf};
        end
    end

    always_comb begin
        oWriteData = resultReg;
        case (memtoReg)
            MemtoRegAlu:  oWriteData = resultReg;
            MemtoRegLoad: oWriteData = loadData;
            MemtoRegLink: oWriteData = pc4Reg;
            default:      oWriteData = resultReg;
        endcase
    end

    assign oRegWrite      = validReg & regWriteBit & (regAddrReg != 5'd0);
    assign oWriteAddr     = regAddrReg;
    assign oControlSignal = controlReg;
    assign oValid         = validReg;
    assign oRetireCount   = retireCountReg;

endmodule
